hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline sequencing controller for the 5-stage MIPS datapath. Decides per cycle
//  whether PC and IF/ID advance, which pipeline registers take a bubble, and which
//  operand source feeds the Execute-stage ALU (forwarding). A small FSM
//  (RUN/STALL/FLUSH) enforces load-use stalls and branch-taken flushes. Saturating
//  counters record stall and flush cycles for the bench.
// PARAMETERS
//  CNT_W  16  width of stall_cnt / flush_cnt; both saturate at 2**CNT_W-1
// PORTS
//  clk            in   1      rising-edge clock
//  rst            in   1      synchronous, active-high reset
//  id_rs, id_rt   in   5      source regs of instr in IF/ID (decode)
//  idex_rs        in   5      ALU operand-A source reg in ID/EX
//  idex_rt        in   5      ALU operand-B source reg and load dest in ID/EX
//  idex_memread   in   1      ID/EX holds a load
//  exmem_rd       in   5      EX/MEM dest reg (five-bit mux result)
//  exmem_regwrite in   1      EX/MEM writes register file
//  exmem_branch   in   1      EX/MEM holds a branch
//  exmem_zero     in   1      EX/MEM ALU zero flag
//  memwb_rd       in   5      MEM/WB dest reg
//  memwb_regwrite in   1      MEM/WB writes register file
//  pc_write       out  1      1 = PC loads next value
//  pcsrc          out  1      1 = PC takes EX/MEM branch target
//  ifid_write     out  1      1 = IF/ID loads; 0 = hold
//  ifid_flush     out  1      1 = IF/ID loads a NOP
//  idex_bubble    out  1      1 = ID/EX control fields (wb/m/ex) loaded as zero
//  exmem_flush    out  1      1 = EX/MEM control fields loaded as zero
//  forward_a      out  2      ALU A select: 00 rdata1, 10 EX/MEM alu_result, 01 MEM/WB data
//  forward_b      out  2      same encoding for ALU B (before alusrc mux)
//  stall_cnt      out  CNT_W  cycles spent inserting a load-use bubble
//  flush_cnt      out  CNT_W  branch-taken flush events
// BEHAVIOUR
//  Reset (rst=1 at edge): state<=RUN, both counters<=0. While rst is high the
//    outputs are pc_write=0, ifid_write=0, pcsrc=0, ifid_flush=1, idex_bubble=1,
//    exmem_flush=1, forward_a/b=00. Reset mid-stall or mid-flush abandons that state.
//  taken = exmem_branch & exmem_zero.
//  luse  = idex_memread & (idex_rt!=0) & (idex_rt==id_rs | idex_rt==id_rt).
//  Outputs are combinational from inputs and state. Decisions have zero latency,
//    and the state updates at the next edge.
//  RUN:
//    taken -> pcsrc=1, pc_write=1, ifid_flush=1, idex_bubble=1, exmem_flush=1.
//      Next state FLUSH; flush_cnt+1.
//    else luse -> pc_write=0, ifid_write=0, idex_bubble=1. Next state STALL;
//      stall_cnt+1.
//    else all advance (pc_write=1, ifid_write=1, flush/bubble=0). Stay in RUN.
//  STALL: the load is now in EX/MEM, so luse is ignored and no second bubble is taken.
//    If taken, handle it as in RUN (next FLUSH). Otherwise all advance and the next
//    state is RUN.
//  FLUSH: wrong-path instrs are already squashed, and all advance this cycle.
//    The branch seen now is a bubble (control fields zero), so taken=0 is expected;
//    if taken=1 anyway, flush again (stay FLUSH, flush_cnt+1). luse is evaluated as
//    in RUN; if true -> stall, next STALL. Otherwise next RUN.
//  Priority: taken > luse > advance, in every state. A branch never loses to a stall.
//  Forwarding (combinational, independent of state, forced 00 during rst):
//    forward_a=10 if exmem_regwrite & exmem_rd!=0 & exmem_rd==idex_rs;
//      else 01 if memwb_regwrite & memwb_rd!=0 & memwb_rd==idex_rs; else 00.
//    forward_b is the same rule using idex_rt. EX/MEM wins when both match.
//    Register $0 never forwards.
//  Counters saturate (no wrap) at all-ones and hold.
// TESTING
//  1 rst high 2 cycles -> pc_write=0, ifid_flush=idex_bubble=exmem_flush=1, counters=0;
//    first cycle after release is RUN with all advance.
//  2 idex_memread=1, idex_rt=8, id_rs=8 -> that cycle pc_write=0, ifid_write=0,
//    idex_bubble=1. Next cycle (STALL, inputs unchanged) advance; stall_cnt=1.
//  3 exmem_branch=1, exmem_zero=1 with luse also true -> pcsrc=1, all three flushes=1,
//    no stall; flush_cnt=1, stall_cnt unchanged.
//  4 exmem_regwrite=1, exmem_rd=5, memwb_regwrite=1, memwb_rd=5, idex_rs=5 ->
//    forward_a=10. Set exmem_rd=0 -> forward_a=01. Set idex_rt=0, memwb_rd=0 ->
//    forward_b=00.
//  5 CNT_W=2, four load-use stalls (separated by clean cycles) -> stall_cnt=3 and holds.
//  6 rst asserted while in STALL -> next cycle state RUN, counters 0, no leftover bubble.

Source files
------------

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline sequencing controller for the 5-stage MIPS datapath. Each cycle it
// decides whether PC and IF/ID advance, which pipeline registers receive a
// bubble, and which operand source feeds each Execute-stage ALU input.
// A three-state FSM (RUN/STALL/FLUSH) handles load-use stalls and
// branch-taken flushes. Two saturating counters record stall and flush events.
//
// Parameters
//   CNT_W           width of stall_cnt / flush_cnt (saturate at all-ones)
//
// Ports
//   clk             rising-edge clock
//   rst             synchronous active-high reset
//   id_rs, id_rt    source registers of the instruction in IF/ID
//   idex_rs         ALU operand-A source register in ID/EX
//   idex_rt         ALU operand-B source register / load destination in ID/EX
//   idex_memread    ID/EX holds a load
//   exmem_rd        EX/MEM destination register
//   exmem_regwrite  EX/MEM writes the register file
//   exmem_branch    EX/MEM holds a branch
//   exmem_zero      EX/MEM ALU zero flag
//   memwb_rd        MEM/WB destination register
//   memwb_regwrite  MEM/WB writes the register file
//   pc_write        1 = PC loads its next value
//   pcsrc           1 = PC takes the EX/MEM branch target
//   ifid_write      1 = IF/ID loads, 0 = hold
//   ifid_flush      1 = IF/ID loads a NOP
//   idex_bubble     1 = ID/EX control fields loaded as zero
//   exmem_flush     1 = EX/MEM control fields loaded as zero
//   forward_a/b     ALU input select: 00 rdata, 10 EX/MEM result, 01 MEM/WB data
//   stall_cnt       load-use bubble cycles inserted
//   flush_cnt       branch-taken flush events
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       idex_rs,
    input  logic [4:0]       idex_rt,
    input  logic             idex_memread,
    input  logic [4:0]       exmem_rd,
    input  logic             exmem_regwrite,
    input  logic             exmem_branch,
    input  logic             exmem_zero,
    input  logic [4:0]       memwb_rd,
    input  logic             memwb_regwrite,
    output logic             pc_write,
    output logic             pcsrc,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             exmem_flush,
    output logic [1:0]       forward_a,
    output logic [1:0]       forward_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic taken;
    logic luse;
    logic do_stall;
    logic do_flush;

    // Hazard detection terms. Register $0 is hard-wired to zero, so a load
    // targeting it can never create a real dependency.
    always_comb begin
        taken = exmem_branch & exmem_zero;
        luse  = idex_memread & (idex_rt != 5'd0) &
                ((idex_rt == id_rs) | (idex_rt == id_rt));
    end

    // Next-state and pipeline-control decode. Priority is reset, then a taken
    // branch, then a load-use stall, then a plain advance. In STALL the load
    // has already moved on to EX/MEM, so the still-visible match is ignored.
    always_comb begin
        pc_write    = 1'b1;
        pcsrc       = 1'b0;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        exmem_flush = 1'b0;
        do_stall    = 1'b0;
        do_flush    = 1'b0;
        state_d     = ST_RUN;

        if (rst) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            exmem_flush = 1'b1;
            state_d     = ST_RUN;
        end else if (taken) begin
            pcsrc       = 1'b1;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            exmem_flush = 1'b1;
            do_flush    = 1'b1;
            state_d     = ST_FLUSH;
        end else if (luse && (state_q != ST_STALL)) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            do_stall    = 1'b1;
            state_d     = ST_STALL;
        end
    end

    // Saturating event counters; cleared by reset, held once all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (rst) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (do_stall && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
            if (do_flush && (flush_cnt_q != CNT_MAX)) begin
                flush_cnt_d = flush_cnt_q + 1'b1;
            end
        end
    end

    // Forwarding select. The newer EX/MEM result wins over MEM/WB, and
    // register $0 never forwards. Forced to the register-file path in reset.
    always_comb begin
        forward_a = 2'b00;
        forward_b = 2'b00;
        if (!rst) begin
            if (exmem_regwrite && (exmem_rd != 5'd0) && (exmem_rd == idex_rs)) begin
                forward_a = 2'b10;
            end else if (memwb_regwrite && (memwb_rd != 5'd0) && (memwb_rd == idex_rs)) begin
                forward_a = 2'b01;
            end
            if (exmem_regwrite && (exmem_rd != 5'd0) && (exmem_rd == idex_rt)) begin
                forward_b = 2'b10;
            end else if (memwb_regwrite && (memwb_rd != 5'd0) && (memwb_rd == idex_rt)) begin
                forward_b = 2'b01;
            end
        end
    end

    // State and counter registers; reset is folded into the _d terms.
    always_ff @(posedge clk) begin
        state_q     <= state_d;
        stall_cnt_q <= stall_cnt_d;
        flush_cnt_q <= flush_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed testbench for hazard_ctrl. A 16-bit-counter instance covers the
// main behaviour; a second instance with CNT_W=2 shares the same stimulus
// and is used to observe counter saturation.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] id_rs, id_rt, idex_rs, idex_rt, exmem_rd, memwb_rd;
    logic       idex_memread, exmem_regwrite, exmem_branch, exmem_zero, memwb_regwrite;

    logic        pc_write, pcsrc, ifid_write, ifid_flush, idex_bubble, exmem_flush;
    logic [1:0]  forward_a, forward_b;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s_pc_write, s_pcsrc, s_ifid_write, s_ifid_flush, s_idex_bubble, s_exmem_flush;
    logic [1:0]  s_forward_a, s_forward_b;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    int vectors;
    int miscompares;

    hazard_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .idex_rs(idex_rs), .idex_rt(idex_rt),
        .idex_memread(idex_memread), .exmem_rd(exmem_rd),
        .exmem_regwrite(exmem_regwrite), .exmem_branch(exmem_branch),
        .exmem_zero(exmem_zero), .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite),
        .pc_write(pc_write), .pcsrc(pcsrc), .ifid_write(ifid_write),
        .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .exmem_flush(exmem_flush),
        .forward_a(forward_a), .forward_b(forward_b),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_ctrl #(.CNT_W(2)) dut_small (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .idex_rs(idex_rs), .idex_rt(idex_rt),
        .idex_memread(idex_memread), .exmem_rd(exmem_rd),
        .exmem_regwrite(exmem_regwrite), .exmem_branch(exmem_branch),
        .exmem_zero(exmem_zero), .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite),
        .pc_write(s_pc_write), .pcsrc(s_pcsrc), .ifid_write(s_ifid_write),
        .ifid_flush(s_ifid_flush), .idex_bubble(s_idex_bubble), .exmem_flush(s_exmem_flush),
        .forward_a(s_forward_a), .forward_b(s_forward_b),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    // Free-running clock, 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends even if the sequence stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance one clock edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Return every hazard input to a neutral value.
    task automatic clear_inputs();
        id_rs = 5'd0; id_rt = 5'd0; idex_rs = 5'd0; idex_rt = 5'd0;
        idex_memread = 1'b0; exmem_rd = 5'd0; exmem_regwrite = 1'b0;
        exmem_branch = 1'b0; exmem_zero = 1'b0; memwb_rd = 5'd0; memwb_regwrite = 1'b0;
        #1;
    endtask

    // Load-use pattern: load into $8 while the decode instruction reads $8.
    task automatic apply_luse();
        idex_memread = 1'b1; idex_rt = 5'd8; id_rs = 5'd8;
        #1;
    endtask

    // Reset held for two cycles forces every control output safe, then the
    // first cycle after release runs with everything advancing.
    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        exmem_regwrite = 1'b1; exmem_rd = 5'd5; idex_rs = 5'd5; idex_rt = 5'd5;
        step(); step();
        vectors++; if (pc_write !== 1'b0) begin $display("[TB] FAIL rst_pc_write: got %b expected 0", pc_write); miscompares++; end
        vectors++; if (ifid_write !== 1'b0) begin $display("[TB] FAIL rst_ifid_write: got %b expected 0", ifid_write); miscompares++; end
        vectors++; if ({ifid_flush, idex_bubble, exmem_flush} !== 3'b111) begin $display("[TB] FAIL rst_flushes: got %b expected 111", {ifid_flush, idex_bubble, exmem_flush}); miscompares++; end
        vectors++; if (pcsrc !== 1'b0) begin $display("[TB] FAIL rst_pcsrc: got %b expected 0", pcsrc); miscompares++; end
        vectors++; if ({forward_a, forward_b} !== 4'b0000) begin $display("[TB] FAIL rst_forward: got %b expected 0000", {forward_a, forward_b}); miscompares++; end
        vectors++; if ({stall_cnt, flush_cnt} !== 32'd0) begin $display("[TB] FAIL rst_counters: got %0d/%0d expected 0/0", stall_cnt, flush_cnt); miscompares++; end
        rst = 1'b0;
        clear_inputs();
        vectors++; if ({pc_write, ifid_write, pcsrc, ifid_flush, idex_bubble, exmem_flush} !== 6'b110000) begin $display("[TB] FAIL post_rst_advance: got %b expected 110000", {pc_write, ifid_write, pcsrc, ifid_flush, idex_bubble, exmem_flush}); miscompares++; end
        step();
    endtask

    // A load-use dependency bubbles once; in STALL the same inputs advance.
    task automatic test_load_use();
        apply_luse();
        vectors++; if ({pc_write, ifid_write, idex_bubble, ifid_flush} !== 4'b0010) begin $display("[TB] FAIL luse_stall: got %b expected 0010", {pc_write, ifid_write, idex_bubble, ifid_flush}); miscompares++; end
        step();
        vectors++; if ({pc_write, ifid_write, idex_bubble} !== 3'b110) begin $display("[TB] FAIL luse_release: got %b expected 110", {pc_write, ifid_write, idex_bubble}); miscompares++; end
        vectors++; if (stall_cnt !== 16'd1) begin $display("[TB] FAIL luse_stall_cnt: got %0d expected 1", stall_cnt); miscompares++; end
        step();
        clear_inputs();
        // Match through id_rt also stalls.
        idex_memread = 1'b1; idex_rt = 5'd3; id_rt = 5'd3; #1;
        vectors++; if (pc_write !== 1'b0) begin $display("[TB] FAIL luse_rt_stall: got %b expected 0", pc_write); miscompares++; end
        step();
        clear_inputs();
        step();
        // A load into $0 never stalls.
        idex_memread = 1'b1; idex_rt = 5'd0; id_rs = 5'd0; #1;
        vectors++; if ({pc_write, idex_bubble} !== 2'b10) begin $display("[TB] FAIL luse_r0: got %b expected 10", {pc_write, idex_bubble}); miscompares++; end
        // Without a memread there is no stall either.
        idex_memread = 1'b0; idex_rt = 5'd9; id_rs = 5'd9; #1;
        vectors++; if (pc_write !== 1'b1) begin $display("[TB] FAIL luse_no_load: got %b expected 1", pc_write); miscompares++; end
        clear_inputs();
    endtask

    // Taken branch beats a simultaneous load-use; then FLUSH honours load-use,
    // a repeat taken branch in FLUSH flushes again, and STALL honours a branch.
    task automatic test_branch();
        apply_luse();
        exmem_branch = 1'b1; exmem_zero = 1'b1; #1;
        vectors++; if ({pcsrc, pc_write, ifid_flush, idex_bubble, exmem_flush} !== 5'b11111) begin $display("[TB] FAIL br_priority: got %b expected 11111", {pcsrc, pc_write, ifid_flush, idex_bubble, exmem_flush}); miscompares++; end
        step();
        vectors++; if (flush_cnt !== 16'd1) begin $display("[TB] FAIL br_flush_cnt: got %0d expected 1", flush_cnt); miscompares++; end
        vectors++; if (stall_cnt !== 16'd2) begin $display("[TB] FAIL br_stall_cnt_held: got %0d expected 2", stall_cnt); miscompares++; end
        // In FLUSH, load-use still applies.
        exmem_branch = 1'b0; exmem_zero = 1'b0; #1;
        vectors++; if ({pcsrc, pc_write, ifid_write, idex_bubble, exmem_flush} !== 5'b00010) begin $display("[TB] FAIL flush_luse: got %b expected 00010", {pcsrc, pc_write, ifid_write, idex_bubble, exmem_flush}); miscompares++; end
        step();
        vectors++; if (stall_cnt !== 16'd3) begin $display("[TB] FAIL flush_luse_cnt: got %0d expected 3", stall_cnt); miscompares++; end
        // Now in STALL: a taken branch is handled.
        exmem_branch = 1'b1; exmem_zero = 1'b1; #1;
        vectors++; if ({pcsrc, exmem_flush} !== 2'b11) begin $display("[TB] FAIL stall_taken: got %b expected 11", {pcsrc, exmem_flush}); miscompares++; end
        step();
        // In FLUSH with taken again: flush again and stay in FLUSH.
        clear_inputs();
        exmem_branch = 1'b1; exmem_zero = 1'b1; #1;
        vectors++; if (pcsrc !== 1'b1) begin $display("[TB] FAIL flush_retaken: got %b expected 1", pcsrc); miscompares++; end
        step();
        vectors++; if (flush_cnt !== 16'd3) begin $display("[TB] FAIL flush_retaken_cnt: got %0d expected 3", flush_cnt); miscompares++; end
        clear_inputs();
        vectors++; if ({pc_write, ifid_write, pcsrc, ifid_flush, idex_bubble, exmem_flush} !== 6'b110000) begin $display("[TB] FAIL flush_advance: got %b expected 110000", {pc_write, ifid_write, pcsrc, ifid_flush, idex_bubble, exmem_flush}); miscompares++; end
        // Branch without zero is not taken.
        exmem_branch = 1'b1; exmem_zero = 1'b0; #1;
        vectors++; if (pcsrc !== 1'b0) begin $display("[TB] FAIL br_not_taken: got %b expected 0", pcsrc); miscompares++; end
        step();
        clear_inputs();
        step();
    endtask

    // Forwarding select, including EX/MEM priority and $0 suppression.
    task automatic test_forwarding();
        clear_inputs();
        exmem_regwrite = 1'b1; exmem_rd = 5'd5; memwb_regwrite = 1'b1; memwb_rd = 5'd5; idex_rs = 5'd5; #1;
        vectors++; if (forward_a !== 2'b10) begin $display("[TB] FAIL fwd_a_exmem: got %b expected 10", forward_a); miscompares++; end
        exmem_rd = 5'd0; #1;
        vectors++; if (forward_a !== 2'b01) begin $display("[TB] FAIL fwd_a_memwb: got %b expected 01", forward_a); miscompares++; end
        idex_rt = 5'd5; #1;
        vectors++; if (forward_b !== 2'b01) begin $display("[TB] FAIL fwd_b_memwb: got %b expected 01", forward_b); miscompares++; end
        exmem_rd = 5'd5; #1;
        vectors++; if (forward_b !== 2'b10) begin $display("[TB] FAIL fwd_b_exmem: got %b expected 10", forward_b); miscompares++; end
        exmem_regwrite = 1'b0; #1;
        vectors++; if ({forward_a, forward_b} !== 4'b0101) begin $display("[TB] FAIL fwd_no_regwrite: got %b expected 0101", {forward_a, forward_b}); miscompares++; end
        idex_rt = 5'd0; memwb_rd = 5'd0; #1;
        vectors++; if (forward_b !== 2'b00) begin $display("[TB] FAIL fwd_b_r0: got %b expected 00", forward_b); miscompares++; end
        vectors++; if (forward_a !== 2'b00) begin $display("[TB] FAIL fwd_a_none: got %b expected 00", forward_a); miscompares++; end
        clear_inputs();
    endtask

    // Four separated stalls: the 2-bit counter sticks at 3, the wide one keeps counting.
    task automatic test_saturation();
        rst = 1'b1;
        step();
        rst = 1'b0;
        clear_inputs();
        for (int n = 1; n <= 4; n++) begin
            apply_luse();
            step();
            clear_inputs();
            step();
            step();
            vectors++; if (s_stall_cnt !== ((n > 3) ? 2'd3 : 2'(n))) begin $display("[TB] FAIL sat_small_%0d: got %0d expected %0d", n, s_stall_cnt, (n > 3) ? 3 : n); miscompares++; end
            vectors++; if (stall_cnt !== 16'(n)) begin $display("[TB] FAIL sat_wide_%0d: got %0d expected %0d", n, stall_cnt, n); miscompares++; end
        end
        step();
        vectors++; if (s_stall_cnt !== 2'd3) begin $display("[TB] FAIL sat_hold: got %0d expected 3", s_stall_cnt); miscompares++; end
    endtask

    // Reset while in STALL returns to RUN with cleared counters and no bubble.
    task automatic test_reset_mid_stall();
        apply_luse();
        step();
        vectors++; if (pc_write !== 1'b1) begin $display("[TB] FAIL mid_in_stall: got %b expected 1", pc_write); miscompares++; end
        rst = 1'b1; #1;
        vectors++; if ({pc_write, idex_bubble} !== 2'b01) begin $display("[TB] FAIL mid_rst_outputs: got %b expected 01", {pc_write, idex_bubble}); miscompares++; end
        step();
        rst = 1'b0;
        clear_inputs();
        vectors++; if ({pc_write, ifid_write, idex_bubble, ifid_flush, exmem_flush} !== 5'b11000) begin $display("[TB] FAIL mid_no_bubble: got %b expected 11000", {pc_write, ifid_write, idex_bubble, ifid_flush, exmem_flush}); miscompares++; end
        vectors++; if ({stall_cnt, flush_cnt} !== 32'd0) begin $display("[TB] FAIL mid_counters: got %0d/%0d expected 0/0", stall_cnt, flush_cnt); miscompares++; end
        // Being in RUN, a load-use now stalls again.
        apply_luse();
        vectors++; if (pc_write !== 1'b0) begin $display("[TB] FAIL mid_state_run: got %b expected 0", pc_write); miscompares++; end
        step();
        clear_inputs();
        step();
    endtask

    // Test sequence.
    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        clear_inputs();
        test_reset();
        test_load_use();
        test_branch();
        test_forwarding();
        test_saturation();
        test_reset_mid_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
